// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM state encoding
// and BCD digit limits.
package stopwatch_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  // Counting happens in both RUN and LAP; LAP only freezes the display.
  function automatic logic is_counting(input sw_state_e st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Key-pulse inputs and display outputs of the stopwatch controller. The key
// logic drives the master side; the controller sits on the slave side.
interface stopwatch_ctrl_if import stopwatch_pkg::*; #(
  parameter int NUM_DIGITS = 4
) ();

  logic                            i_start_stop;
  logic                            i_clear;
  logic                            i_lap;
  logic [DIGIT_W*NUM_DIGITS-1:0]   o_digits;
  logic                            o_running;
  logic                            o_lap_active;
  logic                            o_overflow;

  modport master (
    output i_start_stop, i_clear, i_lap,
    input  o_digits, o_running, o_lap_active, o_overflow
  );

  modport slave (
    input  i_start_stop, i_clear, i_lap,
    output o_digits, o_running, o_lap_active, o_overflow
  );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decimal digit of the stopwatch cascade: counts 0..9 on i_inc, wraps to 0,
// and reports a registered "currently at 9" flag for the carry chain.
module bcd_digit import stopwatch_pkg::*; (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [DIGIT_W-1:0] o_val,
  output logic               o_at_max
);

  logic [3:0] val_r;
  logic [3:0] val_nxt_s;
  logic       at_max_r;

  // Next digit value: clear wins, otherwise increment with 9->0 wrap.
  always_comb begin
    val_nxt_s = val_r;
    if (i_clr) begin
      val_nxt_s = 4'd0;
    end else if (i_inc) begin
      val_nxt_s = (val_r == BCD_MAX) ? 4'd0 : (val_r + 4'd1);
    end else begin
      val_nxt_s = val_r;
    end
  end

  // Digit register and its at-9 flag, kept in step with each other.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      val_r    <= 4'd0;
      at_max_r <= 1'b0;
    end else begin
      val_r    <= val_nxt_s;
      at_max_r <= (val_nxt_s == BCD_MAX);
    end
  end

  assign o_val    = val_r;
  assign o_at_max = at_max_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch: tick prescaler, 4-state control FSM, lap snapshot
// and a cascade of bcd_digit counters driving the display digits.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int NUM_DIGITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int                  PRESC_W    = $clog2(TICK_DIV);
  localparam int                  DW         = DIGIT_W * NUM_DIGITS;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  sw_state_e             state_r;
  logic [PRESC_W-1:0]    presc_r;
  logic [DW-1:0]         snap_r;
  logic [DW-1:0]         digits_r;
  logic                  running_r;
  logic                  lap_active_r;
  logic                  overflow_r;

  logic                  clr_s;
  logic                  ss_s;
  logic                  lap_s;
  logic                  run_s;
  logic                  tick_s;
  logic                  clr_acc_s;
  logic [DW-1:0]         live_s;
  logic [NUM_DIGITS-1:0] at_max_s;
  logic [NUM_DIGITS-1:0] inc_s;

  // Coincident pulses: clear beats start_stop beats lap; losers are dropped.
  assign clr_s     = bus.i_clear;
  assign ss_s      = bus.i_start_stop & ~bus.i_clear;
  assign lap_s     = bus.i_lap & ~bus.i_start_stop & ~bus.i_clear;
  assign run_s     = is_counting(state_r);
  assign tick_s    = run_s && (presc_r == PRESC_LAST);
  assign clr_acc_s = clr_s && ((state_r == ST_IDLE) || (state_r == ST_PAUSE));

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign inc_s[k] = tick_s;
    end else begin : g_upper
      assign inc_s[k] = tick_s & (&at_max_s[k-1:0]);
    end

    bcd_digit u_digit (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (clr_acc_s),
      .i_inc    (inc_s[k]),
      .o_val    (live_s[DIGIT_W*k +: DIGIT_W]),
      .o_at_max (at_max_s[k])
    );
  end

  // Control FSM with running/lap flags registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      running_r    <= 1'b0;
      lap_active_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ss_s) begin
            state_r <= ST_RUN;  running_r <= 1'b1; lap_active_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE; running_r <= 1'b0; lap_active_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ss_s) begin
            state_r <= ST_PAUSE; running_r <= 1'b0; lap_active_r <= 1'b0;
          end else if (lap_s) begin
            state_r <= ST_LAP;   running_r <= 1'b1; lap_active_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;   running_r <= 1'b1; lap_active_r <= 1'b0;
          end
        end
        ST_LAP: begin
          if (ss_s) begin
            state_r <= ST_PAUSE; running_r <= 1'b0; lap_active_r <= 1'b0;
          end else if (lap_s) begin
            state_r <= ST_RUN;   running_r <= 1'b1; lap_active_r <= 1'b0;
          end else begin
            state_r <= ST_LAP;   running_r <= 1'b1; lap_active_r <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (clr_s) begin
            state_r <= ST_IDLE;  running_r <= 1'b0; lap_active_r <= 1'b0;
          end else if (ss_s) begin
            state_r <= ST_RUN;   running_r <= 1'b1; lap_active_r <= 1'b0;
          end else begin
            state_r <= ST_PAUSE; running_r <= 1'b0; lap_active_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE; running_r <= 1'b0; lap_active_r <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler, lap snapshot, sticky overflow and the registered display.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_r    <= '0;
      snap_r     <= '0;
      overflow_r <= 1'b0;
      digits_r   <= '0;
    end else begin
      if (clr_acc_s || tick_s) begin
        presc_r <= '0;
      end else if (run_s) begin
        presc_r <= presc_r + PRESC_W'(1);
      end

      // Snapshot samples the pre-increment live value, even on a tick edge.
      if (clr_acc_s) begin
        snap_r <= '0;
      end else if ((state_r == ST_RUN) && lap_s) begin
        snap_r <= live_s;
      end

      if (clr_acc_s) begin
        overflow_r <= 1'b0;
      end else if (tick_s && (&at_max_s)) begin
        overflow_r <= 1'b1;
      end

      digits_r <= (state_r == ST_LAP) ? snap_r : live_s;
    end
  end

  assign bus.o_digits     = digits_r;
  assign bus.o_running    = running_r;
  assign bus.o_lap_active = lap_active_r;
  assign bus.o_overflow   = overflow_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a decimal-integer reference model pushes
// expected outputs into a scoreboard queue each cycle; they are popped after the edge.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  typedef struct {
    int          dut;
    logic [15:0] dig;
    logic        run;
    logic        lap;
    logic        ovf;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model state per DUT: 0 idle, 1 run, 2 pause, 3 lap.
  int m_state[2];
  int m_presc[2];
  int m_count[2];
  int m_snap[2];
  int m_disp[2];
  int m_over[2];
  int m_mod[2] = '{10000, 100};

  always #5 i_clk = ~i_clk;

  stopwatch_ctrl_if #(.NUM_DIGITS(4)) bus4 ();
  stopwatch_ctrl_if #(.NUM_DIGITS(2)) bus2 ();

  stopwatch_ctrl #(.TICK_DIV(TD), .NUM_DIGITS(4)) dut4 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus4.slave)
  );

  stopwatch_ctrl #(.TICK_DIV(TD), .NUM_DIGITS(2)) dut2 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus2.slave)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_presc[d] = 0; m_count[d] = 0;
      m_snap[d]  = 0; m_disp[d]  = 0; m_over[d]  = 0;
    end
  endtask

  task automatic model_edge(input int d, input bit ss, input bit clr, input bit lp);
    int   st;
    bit   run, tick, acc;
    exp_t e;
    st   = m_state[d];
    run  = (st == 1) || (st == 3);
    tick = run && (m_presc[d] == TD - 1);
    acc  = clr && ((st == 0) || (st == 2));
    m_disp[d] = (st == 3) ? m_snap[d] : m_count[d];
    if (acc) m_snap[d] = 0;
    else if (st == 1 && !clr && !ss && lp) m_snap[d] = m_count[d];
    if (acc) m_over[d] = 0;
    else if (tick && m_count[d] == m_mod[d] - 1) m_over[d] = 1;
    if (acc) m_count[d] = 0;
    else if (tick) m_count[d] = (m_count[d] + 1) % m_mod[d];
    if (acc || tick) m_presc[d] = 0;
    else if (run) m_presc[d] = m_presc[d] + 1;
    if (clr) m_state[d] = (st == 0 || st == 2) ? 0 : st;
    else if (ss) m_state[d] = (st == 0 || st == 2) ? 1 : 2;
    else if (lp) m_state[d] = (st == 1) ? 3 : (st == 3) ? 1 : st;
    e.dut = d;
    e.dig = to_bcd(m_disp[d]);
    e.run = (m_state[d] == 1) || (m_state[d] == 3);
    e.lap = (m_state[d] == 3);
    e.ovf = (m_over[d] != 0);
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [15:0] dig;
    logic        run, lap, ovf;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        dig = bus4.o_digits; run = bus4.o_running; lap = bus4.o_lap_active; ovf = bus4.o_overflow;
      end else begin
        dig = {8'h00, bus2.o_digits}; run = bus2.o_running; lap = bus2.o_lap_active; ovf = bus2.o_overflow;
      end
      chk($sformatf("sb%0d_digits", e.dut), dig, e.dig);
      chk($sformatf("sb%0d_running", e.dut), {15'd0, run}, {15'd0, e.run});
      chk($sformatf("sb%0d_lap", e.dut), {15'd0, lap}, {15'd0, e.lap});
      chk($sformatf("sb%0d_overflow", e.dut), {15'd0, ovf}, {15'd0, e.ovf});
    end
  endtask

  // One clock: drive pulses to DUT d (the other idles), predict, then compare.
  task automatic step(input int d, input bit ss, input bit clr, input bit lp);
    @(negedge i_clk);
    bus4.i_start_stop = (d == 0) ? ss : 1'b0;
    bus4.i_clear      = (d == 0) ? clr : 1'b0;
    bus4.i_lap        = (d == 0) ? lp : 1'b0;
    bus2.i_start_stop = (d == 1) ? ss : 1'b0;
    bus2.i_clear      = (d == 1) ? clr : 1'b0;
    bus2.i_lap        = (d == 1) ? lp : 1'b0;
    model_edge(0, (d == 0) && ss, (d == 0) && clr, (d == 0) && lp);
    model_edge(1, (d == 1) && ss, (d == 1) && clr, (d == 1) && lp);
    @(posedge i_clk);
    #1;
    bus4.i_start_stop = 1'b0; bus4.i_clear = 1'b0; bus4.i_lap = 1'b0;
    bus2.i_start_stop = 1'b0; bus2.i_clear = 1'b0; bus2.i_lap = 1'b0;
    check_sb();
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1;
    bus4.i_start_stop = 1'b0; bus4.i_clear = 1'b0; bus4.i_lap = 1'b0;
    bus2.i_start_stop = 1'b0; bus2.i_clear = 1'b0; bus2.i_lap = 1'b0;
    model_reset();
    #12;
    chk("reset_digits", bus4.o_digits, 16'h0000);
    chk("reset_flags", {13'd0, bus4.o_running, bus4.o_lap_active, bus4.o_overflow}, 16'h0000);
    chk("reset_digits2", {8'h00, bus2.o_digits}, 16'h0000);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset while running at 0037.
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && m_count[0] != 37; i++) idle(0, 1);
    idle(0, 1);
    chk("pre_reset_0037", bus4.o_digits, 16'h0037);
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    chk("async_reset_digits", bus4.o_digits, 16'h0000);
    chk("async_reset_flags", {13'd0, bus4.o_running, bus4.o_lap_active, bus4.o_overflow}, 16'h0000);
    @(posedge i_clk);
    #1;
    chk("reset_hold_digits", bus4.o_digits, 16'h0000);
    @(negedge i_clk);
    i_rst = 1'b0;

    // First tick latency and decimal carry.
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      idle(0, 1);
      if (i == 4) chk("first_tick_hold", bus4.o_digits, 16'h0000);
      if (i == 5) chk("first_tick", bus4.o_digits, 16'h0001);
    end
    idle(0, 36);
    chk("carry_0010", bus4.o_digits, 16'h0010);

    // Clear ignored in RUN; pause at prescaler 2 keeps phase across resume.
    step(0, 1'b0, 1'b1, 1'b0);
    chk("clear_in_run_ignored", {15'd0, bus4.o_running}, 16'h0001);
    step(0, 1'b1, 1'b0, 1'b0);
    idle(0, 20);
    chk("paused", {15'd0, bus4.o_running}, 16'h0000);
    step(0, 1'b1, 1'b0, 1'b0);
    idle(0, 1);
    chk("resume_before_tick", bus4.o_digits, 16'h0010);
    idle(0, 1);
    chk("resume_tick", bus4.o_digits, 16'h0011);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    idle(0, 1);
    chk("clear_in_pause", bus4.o_digits, 16'h0000);

    // Lap freeze at 0012, release at 0024.
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && m_count[0] != 12; i++) idle(0, 1);
    step(0, 1'b0, 1'b0, 1'b1);
    idle(0, 4 * 12);
    chk("lap_frozen", bus4.o_digits, 16'h0012);
    chk("lap_active", {15'd0, bus4.o_lap_active}, 16'h0001);
    for (int i = 0; i < 200 && m_count[0] != 24; i++) idle(0, 1);
    step(0, 1'b0, 1'b0, 1'b1);
    idle(0, 1);
    chk("lap_release", bus4.o_digits, 16'h0024);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);

    // Two-digit instance: overflow from 99 is sticky until cleared.
    step(1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 600 && m_count[1] != 99; i++) idle(1, 1);
    idle(1, 1);
    chk("n2_at_99", {8'h00, bus2.o_digits}, 16'h0099);
    for (int i = 0; i < 20 && m_count[1] != 0; i++) idle(1, 1);
    idle(1, 1);
    chk("n2_wrapped", {8'h00, bus2.o_digits}, 16'h0000);
    chk("n2_overflow", {15'd0, bus2.o_overflow}, 16'h0001);
    idle(1, 10);
    chk("n2_overflow_sticky", {15'd0, bus2.o_overflow}, 16'h0001);
    step(1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1, 1'b0);
    chk("n2_overflow_cleared", {15'd0, bus2.o_overflow}, 16'h0000);

    // Coincident pulses.
    step(0, 1'b1, 1'b0, 1'b0);
    idle(0, 2);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    idle(0, 1);
    chk("clear_beats_start", {15'd0, bus4.o_running}, 16'h0000);
    chk("clear_beats_start_digits", bus4.o_digits, 16'h0000);
    step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8 && m_presc[0] != TD - 1; i++) idle(0, 1);
    step(0, 1'b1, 1'b0, 1'b1);
    chk("start_beats_lap", {14'd0, bus4.o_running, bus4.o_lap_active}, 16'h0000);
    idle(0, 1);
    chk("tick_with_stop_counted", bus4.o_digits, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
